stb_switch_ctrl: RTL and testbench
==================================

Name: stb_switch_ctrl

Overview:
- Sequencer/arbiter that owns the 6-bit control word of the STB/DTB port switch.
- Shares the switched port between the SPI master and the I2C master, with round-robin arbitration.
- Inserts settle guard times around every control-word change so chip-select and mode lines never glitch while a master is on the bus.
- Parks the switch in a safe idle mode: STB/I2C with cs=0 when the board is an STB, otherwise DTB.

Parameters:
- SETTLE_CYCLES, 8, guard cycles after each control-word change; legal range 1..255.
- CNT_W, 8, settle/timeout counter width.
- TIMEOUT_CYCLES, 65535, maximum grant hold time; used only with the optional feature.

Ports:
- clk  in  1  system clock
- nReset  in  1  synchronous active-low reset
- stb_en  in  1  1 = STB adapter present (STB modes allowed); 0 = DTB only
- spi_req  in  1  SPI master requests the port
- spi_cs_req  in  3  requested chip select
- spi_pol_req  in  1  requested SCLK polarity
- spi_gnt  out  1  SPI owns the port
- spi_done  in  1  one-cycle release pulse from SPI master
- i2c_req  in  1  I2C master requests the port
- i2c_gnt  out  1  I2C owns the port
- i2c_done  in  1  one-cycle release pulse from I2C master
- ctrl  out  6  switch control {mode_stb, mode_spi, spi_pol, spi_cs[2:0]}
- busy  out  1  high in any state except IDLE
- timeout_err  out  1  sticky watchdog flag (optional feature)
- err_clr  in  1  clears timeout_err (optional feature)

Behaviour:
- All outputs are registered.
- Reset (nReset=0 at a clk edge): state=IDLE, ctrl=6'b000000 (DTB), spi_gnt=i2c_gnt=0, busy=0, timeout_err=0, last owner=I2C (SPI wins the first tie).
- Park word, evaluated every IDLE cycle: stb_en=1 gives 6'b100000 (STB/I2C, cs=0); stb_en=0 gives 6'b000000.
- IDLE:
  - With stb_en=0, requests are ignored and stay pending.
  - With stb_en=1, the winner is chosen: the single requester; or, if both request, the one that was not last owner.
  - On selection, spi_cs_req/spi_pol_req are captured.
  - ctrl is loaded next cycle: SPI gives {1,1,pol,cs}; I2C gives {1,0,0,000}. The FSM then enters SETUP.
- SETUP: counts SETTLE_CYCLES. The owner's gnt rises on the cycle after the count expires, and the FSM enters GRANT.
- Latency: a req sampled in IDLE at cycle N gives ctrl valid at N+1 and gnt high at N+1+SETTLE_CYCLES.
- Request protocol: req must be held until gnt. req is sampled only in IDLE; a later drop of req does not abort.
- GRANT:
  - ctrl is frozen.
  - The owner's done pulse gives gnt=0 and ctrl=park word at the next edge; the FSM enters RELEASE and last owner is updated.
  - The non-owner's done, and done outside GRANT, are ignored.
- RELEASE: counts SETTLE_CYCLES, then returns to IDLE. busy=0 at the first IDLE cycle, and a new request is accepted in that same cycle. A pending request therefore gets at least 2*SETTLE_CYCLES+2 cycles between owners.
- stb_en is sampled only in IDLE. A change during SETUP/GRANT/RELEASE takes effect at the next IDLE.
- spi_gnt and i2c_gnt are never high together. gnt is never high while ctrl is changing.
- A mid-operation reset returns to the reset state at the next edge regardless of state.
- Counter: a loadable down-counter of CNT_W bits; SETTLE_CYCLES must fit in CNT_W.

Optional Feature:
- Macro: STB_SWITCH_CTRL_TIMEOUT_EN.
- With the macro:
  - A CNT_W-wide-or-wider watchdog counts GRANT cycles.
  - Reaching TIMEOUT_CYCLES forces the same transition as done (gnt=0, park, RELEASE) and sets timeout_err=1.
  - timeout_err stays set until err_clr=1 or reset. err_clr and a new timeout in the same cycle leave timeout_err set.
- Without the macro: no watchdog logic, timeout_err is tied to 0, and err_clr is unused.

Decomposition:
- Package stb_switch_pkg:
  - ctrl bit index constants (MODE_STB=5, MODE_SPI=4, SPI_POL=3, CS_LSB=0).
  - Park words CTRL_DTB, CTRL_STB_IDLE.
  - FSM state enum {IDLE, SETUP, GRANT, RELEASE}.
  - Owner enum {OWN_SPI, OWN_I2C}.
- One sub-module, stb_settle_timer: load/count/expire pulse. It is reused for the settle timing and, with the macro, the watchdog.

Test Plan:
- Reset with stb_en=1, no requests: ctrl goes 000000 then 100000 one cycle after reset release; busy=0; both gnts 0.
- spi_req=1, spi_cs_req=3'b101, spi_pol_req=1, SETTLE_CYCLES=8: ctrl=6'b111101 at N+1, spi_gnt=1 at N+9. spi_done at M gives spi_gnt=0 and ctrl=100000 at M+1, and busy=0 at M+9.
- spi_req and i2c_req raised in the same cycle after reset: SPI is granted first. After its done and RELEASE, I2C is granted (ctrl=100000, i2c_gnt after 8 cycles). Repeating both requests then grants I2C... no: the next tie goes to SPI again, alternating strictly.
- stb_en=0 with i2c_req=1: ctrl=000000 and i2c_gnt stays 0 indefinitely. Raising stb_en=1 gives ctrl=100000, then a grant 8 cycles later.
- nReset=0 asserted during GRANT (SPI owner): next edge gives spi_gnt=0, ctrl=000000, busy=0. A stray spi_done after reset has no effect.
- With STB_SWITCH_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=100, hold i2c_gnt without done: i2c_gnt falls after 100 GRANT cycles and timeout_err=1 stays set; a one-cycle err_clr pulse clears it.

Source files
------------

// File: rtl/stb_switch_pkg.sv
// Shared constants and types for the STB/DTB port switch sequencer:
// control-word bit layout, park words, FSM states and owner encoding.
package stb_switch_pkg;

  localparam int MODE_STB = 5;
  localparam int MODE_SPI = 4;
  localparam int SPI_POL  = 3;
  localparam int CS_LSB   = 0;

  localparam logic [5:0] CTRL_DTB      = 6'b000000;
  localparam logic [5:0] CTRL_STB_IDLE = 6'b100000;

  typedef enum logic [1:0] {IDLE, SETUP, GRANT, RELEASE} state_t;
  typedef enum logic {OWN_SPI, OWN_I2C} owner_t;

  function automatic logic [5:0] spi_word(input logic pol, input logic [2:0] cs);
    logic [5:0] w;
    w              = '0;
    w[MODE_STB]    = 1'b1;
    w[MODE_SPI]    = 1'b1;
    w[SPI_POL]     = pol;
    w[CS_LSB +: 3] = cs;
    return w;
  endfunction

endpackage

// File: rtl/stb_settle_timer.sv
// Loadable down-counter; expire is high during the last counted cycle.
// Used for settle guard times and for the grant watchdog.
module stb_settle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!nReset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign expire = (cnt == W'(1));

endmodule

// File: rtl/stb_switch_ctrl.sv
// Round-robin SPI/I2C owner of the STB/DTB switch control word with settle
// guards. Optional grant watchdog: define STB_SWITCH_CTRL_TIMEOUT_EN.
module stb_switch_ctrl
  import stb_switch_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 8,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic       stb_en,
  input  logic       spi_req,
  input  logic [2:0] spi_cs_req,
  input  logic       spi_pol_req,
  output logic       spi_gnt,
  input  logic       spi_done,
  input  logic       i2c_req,
  output logic       i2c_gnt,
  input  logic       i2c_done,
  output logic [5:0] ctrl,
  output logic       busy,
  output logic       timeout_err,
  input  logic       err_clr
);

  state_t     state, state_n;
  owner_t     owner, owner_n, last_own, last_own_n;
  logic [5:0] ctrl_n;
  logic       spi_gnt_n, i2c_gnt_n;
  logic       settle_load, settle_exp;
  logic       wd_load, wd_exp, timeout_hit;
  logic       owner_done;
  owner_t     pick;

  stb_settle_timer #(.W(CNT_W)) u_settle (
    .clk      (clk),
    .nReset   (nReset),
    .load     (settle_load),
    .load_val (CNT_W'(SETTLE_CYCLES)),
    .expire   (settle_exp)
  );

  // Tie goes to whoever did not own the port last.
  always_comb begin
    pick = OWN_SPI;
    if (spi_req && i2c_req)
      pick = (last_own == OWN_SPI) ? OWN_I2C : OWN_SPI;
    else if (i2c_req)
      pick = OWN_I2C;
  end

  assign owner_done = (owner == OWN_SPI) ? spi_done : i2c_done;

  always_comb begin
    state_n     = state;
    ctrl_n      = ctrl;
    spi_gnt_n   = spi_gnt;
    i2c_gnt_n   = i2c_gnt;
    owner_n     = owner;
    last_own_n  = last_own;
    settle_load = 1'b0;
    wd_load     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        ctrl_n = stb_en ? CTRL_STB_IDLE : CTRL_DTB;
        if (stb_en && (spi_req || i2c_req)) begin
          owner_n     = pick;
          ctrl_n      = (pick == OWN_SPI) ? spi_word(spi_pol_req, spi_cs_req) : CTRL_STB_IDLE;
          settle_load = 1'b1;
          state_n     = SETUP;
        end
      end
      SETUP: begin
        if (settle_exp) begin
          spi_gnt_n = (owner == OWN_SPI);
          i2c_gnt_n = (owner == OWN_I2C);
          wd_load   = 1'b1;
          state_n   = GRANT;
        end
      end
      GRANT: begin
        if (owner_done || wd_exp) begin
          spi_gnt_n   = 1'b0;
          i2c_gnt_n   = 1'b0;
          // A grant only exists when stb_en was 1 in IDLE, so park in STB mode.
          ctrl_n      = CTRL_STB_IDLE;
          last_own_n  = owner;
          settle_load = 1'b1;
          timeout_hit = wd_exp;
          state_n     = RELEASE;
        end
      end
      RELEASE: begin
        if (settle_exp)
          state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state    <= IDLE;
      ctrl     <= CTRL_DTB;
      spi_gnt  <= 1'b0;
      i2c_gnt  <= 1'b0;
      busy     <= 1'b0;
      owner    <= OWN_I2C;
      last_own <= OWN_I2C;
    end else begin
      state    <= state_n;
      ctrl     <= ctrl_n;
      spi_gnt  <= spi_gnt_n;
      i2c_gnt  <= i2c_gnt_n;
      busy     <= (state_n != IDLE);
      owner    <= owner_n;
      last_own <= last_own_n;
    end
  end

`ifdef STB_SWITCH_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WD_W = (CNT_W > TO_W) ? CNT_W : TO_W;

  stb_settle_timer #(.W(WD_W)) u_wd (
    .clk      (clk),
    .nReset   (nReset),
    .load     (wd_load),
    .load_val (WD_W'(TIMEOUT_CYCLES)),
    .expire   (wd_exp)
  );

  always_ff @(posedge clk) begin
    if (!nReset)
      timeout_err <= 1'b0;
    else if (timeout_hit)
      timeout_err <= 1'b1;
    else if (err_clr)
      timeout_err <= 1'b0;
  end
`else
  logic unused_wd;
  assign wd_exp      = 1'b0;
  assign timeout_err = 1'b0;
  assign unused_wd   = err_clr ^ wd_load ^ timeout_hit ^ (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_stb_switch_ctrl.sv
// Bench for stb_switch_ctrl: directed scenarios plus randomized request
// transactions checked against a transaction-level round-robin/timing model.
module tb_stb_switch_ctrl;

  localparam int S = 8;
  localparam int T = 100;

  logic       clk = 1'b0;
  logic       nReset, stb_en, spi_req, spi_pol_req, spi_done, i2c_req, i2c_done, err_clr;
  logic [2:0] spi_cs_req;
  logic       spi_gnt, i2c_gnt, busy, timeout_err;
  logic [5:0] ctrl;

  int checks   = 0;
  int failures = 0;
  bit last_i2c = 1'b1;

  stb_switch_ctrl #(.SETTLE_CYCLES(S), .CNT_W(8), .TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .nReset      (nReset),
    .stb_en      (stb_en),
    .spi_req     (spi_req),
    .spi_cs_req  (spi_cs_req),
    .spi_pol_req (spi_pol_req),
    .spi_gnt     (spi_gnt),
    .spi_done    (spi_done),
    .i2c_req     (i2c_req),
    .i2c_gnt     (i2c_gnt),
    .i2c_done    (i2c_done),
    .ctrl        (ctrl),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One arbitration round: request in IDLE, settle, hold, release, settle.
  task automatic txn(input bit rs, input bit ri, input logic [2:0] cs, input bit pol,
                     input int hold, input bit stray);
    bit         win_spi;
    logic [5:0] w;
    logic [1:0] g;
    win_spi = rs && (!ri || last_i2c);
    w       = win_spi ? {2'b11, pol, cs} : 6'b100000;
    g       = win_spi ? 2'b10 : 2'b01;
    spi_req = rs; i2c_req = ri; spi_cs_req = cs; spi_pol_req = pol;
    tick(1);
    chk("ctrl_load", 32'(ctrl), 32'(w));
    chk("busy_setup", 32'(busy), 32'h1);
    tick(S - 1);
    chk("gnt_early", 32'({spi_gnt, i2c_gnt}), 32'h0);
    chk("ctrl_setup", 32'(ctrl), 32'(w));
    tick(1);
    chk("gnt_on", 32'({spi_gnt, i2c_gnt}), 32'(g));
    if (win_spi) spi_req = 1'b0; else i2c_req = 1'b0;
    spi_cs_req  = 3'($urandom);
    spi_pol_req = 1'($urandom);
    if (stray) begin
      if (win_spi) i2c_done = 1'b1; else spi_done = 1'b1;
    end
    tick(1);
    spi_done = 1'b0; i2c_done = 1'b0;
    tick(hold);
    chk("ctrl_frozen", 32'(ctrl), 32'(w));
    chk("gnt_hold", 32'({spi_gnt, i2c_gnt}), 32'(g));
    if (win_spi) spi_done = 1'b1; else i2c_done = 1'b1;
    tick(1);
    spi_done = 1'b0; i2c_done = 1'b0;
    chk("gnt_off", 32'({spi_gnt, i2c_gnt}), 32'h0);
    chk("ctrl_park", 32'(ctrl), 32'h20);
    last_i2c = !win_spi;
    tick(S - 1);
    chk("busy_release", 32'(busy), 32'h1);
    tick(1);
    chk("busy_idle", 32'(busy), 32'h0);
  endtask

  initial begin
    nReset = 1'b0; stb_en = 1'b1; spi_req = 1'b0; spi_pol_req = 1'b0; spi_cs_req = 3'b000;
    spi_done = 1'b0; i2c_req = 1'b0; i2c_done = 1'b0; err_clr = 1'b0;

    tick(2);
    chk("rst_ctrl", 32'(ctrl), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_gnt", 32'({spi_gnt, i2c_gnt}), 32'h0);
    chk("rst_err", 32'(timeout_err), 32'h0);
    nReset = 1'b1;
    tick(1);
    chk("park_stb", 32'(ctrl), 32'h20);
    chk("park_busy", 32'(busy), 32'h0);

    txn(1'b1, 1'b0, 3'b101, 1'b1, 3, 1'b0);

    // Tie after reset: SPI first, then strict alternation.
    txn(1'b1, 1'b1, 3'b010, 1'b0, 2, 1'b1);
    txn(1'b0, 1'b1, 3'b000, 1'b0, 1, 1'b0);
    txn(1'b1, 1'b1, 3'b111, 1'b1, 0, 1'b0);
    txn(1'b1, 1'b1, 3'b011, 1'b0, 2, 1'b1);

    spi_req = 1'b0; i2c_req = 1'b1; stb_en = 1'b0;
    tick(1);
    chk("dtb_ctrl", 32'(ctrl), 32'h0);
    tick(15);
    chk("dtb_ctrl_hold", 32'(ctrl), 32'h0);
    chk("dtb_no_gnt", 32'({spi_gnt, i2c_gnt}), 32'h0);
    chk("dtb_busy", 32'(busy), 32'h0);
    stb_en = 1'b1;
    txn(1'b0, 1'b1, 3'b000, 1'b0, 2, 1'b0);

    for (int i = 0; i < 30; i++) begin
      logic [1:0] r;
      r = 2'($urandom_range(1, 3));
      txn(r[0], r[1], 3'($urandom), 1'($urandom), int'($urandom_range(0, 6)),
          1'($urandom));
    end

    spi_req = 1'b1; i2c_req = 1'b0; spi_cs_req = 3'b110; spi_pol_req = 1'b1;
    tick(1 + S);
    chk("pre_rst_gnt", 32'(spi_gnt), 32'h1);
    nReset = 1'b0; spi_req = 1'b0;
    tick(1);
    chk("midrst_gnt", 32'({spi_gnt, i2c_gnt}), 32'h0);
    chk("midrst_ctrl", 32'(ctrl), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    nReset = 1'b1; spi_done = 1'b1;
    tick(1);
    spi_done = 1'b0;
    last_i2c = 1'b1;
    chk("stray_done_gnt", 32'({spi_gnt, i2c_gnt}), 32'h0);
    chk("stray_done_busy", 32'(busy), 32'h0);
    chk("stray_done_ctrl", 32'(ctrl), 32'h20);
    txn(1'b1, 1'b1, 3'b001, 1'b0, 1, 1'b0);

`ifdef STB_SWITCH_CTRL_TIMEOUT_EN
    i2c_req = 1'b1; spi_req = 1'b0;
    tick(1);
    chk("to_ctrl", 32'(ctrl), 32'h20);
    tick(S);
    chk("to_gnt_on", 32'(i2c_gnt), 32'h1);
    i2c_req = 1'b0;
    tick(T - 1);
    chk("to_gnt_last", 32'(i2c_gnt), 32'h1);
    chk("to_err_before", 32'(timeout_err), 32'h0);
    tick(1);
    chk("to_gnt_off", 32'(i2c_gnt), 32'h0);
    chk("to_err_set", 32'(timeout_err), 32'h1);
    chk("to_ctrl_park", 32'(ctrl), 32'h20);
    last_i2c = 1'b1;
    tick(S);
    chk("to_busy_idle", 32'(busy), 32'h0);
    chk("to_err_sticky", 32'(timeout_err), 32'h1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("to_err_clr", 32'(timeout_err), 32'h0);
`else
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("no_wd_err", 32'(timeout_err), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
